stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control and timebase block for the stopwatch. It generates the debounce strobe for the button front-ends and the 100 Hz count tick. It sequences run/pause/clear/lap from the conditioned single-cycle button pulses and drives the enable, clear and display-hold controls of the BCD time counter and display path.

## Interface
- TICK_DIV, 500000: clk cycles per count tick (50 MHz to 100 Hz); legal range 2..2^CNT_W.
- DEB_DIV, 50000: clk cycles per debounce strobe (1 kHz); legal range 2..2^CNT_W.
- CNT_W, 20: prescaler width.

- clk  in  1  system clock; all logic rises on posedge.
- reset  in  1  asynchronous, active-low; synchronous deassertion is handled upstream.
- ss_pulse  in  1  start/stop press, one-cycle pulse.
- lap_pulse  in  1  lap press, one-cycle pulse.
- clr_pulse  in  1  clear press, one-cycle pulse.
- deb_en  out  1  debounce strobe to the button units; one cycle every DEB_DIV.
- tick  out  1  free 100 Hz strobe; one cycle every TICK_DIV.
- count_en  out  1  time-counter increment enable.
- count_clr  out  1  one-cycle time-counter clear.
- display_hold  out  1  display shows the latched lap value.
- hold_load  out  1  one-cycle lap-latch load.
- running  out  1  high in RUN or LAP_RUN.
- lap_count  out  4  laps taken since clear; saturates at 15.

## Operation
- Prescalers:
  - Two free-running counters, 0..DIV-1.
  - The strobe is asserted in the cycle after the counter equals DIV-1; the counter wraps to 0.
  - count_clr also restarts the tick prescaler at 0, so the first tick after a clear arrives a full TICK_DIV later.
- Event arbitration:
  - At most one event is accepted per cycle.
  - Priority: clr > ss > lap. Lower-priority pulses in the same cycle are dropped, not queued.
- FSM states: IDLE, RUN, PAUSE, LAP_RUN, LAP_PAUSE.
- Transitions:
  - IDLE:
    - ss: to RUN.
    - clr: stay, pulse count_clr.
    - lap: ignored.
  - RUN:
    - ss: to PAUSE.
    - lap: to LAP_RUN, pulse hold_load, lap_count+1.
    - clr: ignored.
  - PAUSE:
    - ss: to RUN.
    - clr: to IDLE, pulse count_clr, lap_count to 0.
    - lap: ignored.
  - LAP_RUN:
    - lap: stay, pulse hold_load, lap_count+1.
    - ss: to LAP_PAUSE.
    - clr: to RUN (hold released, counter untouched).
  - LAP_PAUSE:
    - ss: to LAP_RUN.
    - clr or lap: to PAUSE (hold released).
- count_en = tick AND running. No increments occur in IDLE, PAUSE or LAP_PAUSE.
- display_hold is high in LAP_RUN and LAP_PAUSE.
- lap_count saturates at 15. Further laps still pulse hold_load.

## Timing
- Reset values: all outputs 0, state IDLE, prescalers 0. Reset is effective immediately and asynchronously, including mid-lap or mid-count.
- Latency:
  - A pulse accepted in cycle N updates state, running and display_hold in cycle N+1.
  - count_clr and hold_load are high in cycle N+1 only.
- count_en:
  - Combinational from registered tick and registered state.
  - A tick coinciding with the ss that stops the count still increments, because the state is unchanged in that cycle.
- First tick:
  - After reset deassertion, the first tick is in cycle TICK_DIV and the first deb_en is in cycle DEB_DIV (cycle 1 is the first active edge).
  - When DIVs are equal, the strobes coincide.
- Back-to-back pulses on consecutive cycles are each accepted, so ss,ss returns to the original state.

## Configuration
- STOPWATCH_LAP_EN defined: full behaviour as above.
- STOPWATCH_LAP_EN undefined:
  - LAP_RUN and LAP_PAUSE, lap arbitration and the lap counter are not built.
  - lap_pulse is ignored.
  - display_hold, hold_load and lap_count are tied to 0.
  - clr in RUN is still ignored.

## Test plan
- TICK_DIV=4, DEB_DIV=2, reset released: tick in cycles 4,8,12 and deb_en every 2nd cycle. Count_en stays 0 while IDLE.
- IDLE, ss at cycle 10: running=1 from cycle 11. Count_en pulses coincide with tick and stop one cycle after a second ss.
- RUN, lap twice then ss then lap:
  - hold_load pulses twice and lap_count=2.
  - State becomes LAP_PAUSE, then PAUSE; display_hold goes 1 then 0.
- PAUSE with clr+ss+lap in the same cycle:
  - Only clr is taken: IDLE, count_clr for one cycle, lap_count=0.
  - The next tick arrives 4 cycles later.
- 16 laps in LAP_RUN: lap_count holds 15 and hold_load pulses all 16 times.
- Reset asserted mid-LAP_RUN: all outputs 0 immediately. After release, the FSM is in IDLE and tick restarts at cycle 4.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch timebase (debounce strobe, count tick) and run/pause/clear/lap sequencer.
// Lap support (lap states, lap latch control, lap counter) is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 500000,
    parameter int DEB_DIV  = 50000,
    parameter int CNT_W    = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ss_pulse,
    input  logic       lap_pulse,
    input  logic       clr_pulse,
    output logic       deb_en,
    output logic       tick,
    output logic       count_en,
    output logic       count_clr,
    output logic       display_hold,
    output logic       hold_load,
    output logic       running,
    output logic [3:0] lap_count
);

    localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE
`ifdef STOPWATCH_LAP_EN
        ,
        S_LAP_RUN,
        S_LAP_PAUSE
`endif
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] tick_cnt, deb_cnt;
    logic             ev_clr, ev_ss;
    logic             clr_take, load_take;

    // Fixed priority clr > ss > lap; losers are dropped even if the winner is ignored.
    assign ev_clr = clr_pulse;
    assign ev_ss  = ss_pulse & ~clr_pulse;

`ifdef STOPWATCH_LAP_EN
    logic ev_lap;
    assign ev_lap = lap_pulse & ~ss_pulse & ~clr_pulse;
`else
    logic unused_lap;
    assign unused_lap = lap_pulse;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_cnt <= '0;
            deb_en  <= 1'b0;
        end else begin
            deb_en  <= (deb_cnt == DEB_MAX);
            deb_cnt <= (deb_cnt == DEB_MAX) ? '0 : deb_cnt + CNT_W'(1);
        end
    end

    // A clear restarts the tick phase so the first tick comes a full period later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else if (clr_take) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick     <= (tick_cnt == TICK_MAX);
            tick_cnt <= (tick_cnt == TICK_MAX) ? '0 : tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            count_clr <= 1'b0;
            hold_load <= 1'b0;
        end else begin
            state     <= state_nx;
            count_clr <= clr_take;
            hold_load <= load_take;
        end
    end

    always_comb begin
        state_nx  = state;
        clr_take  = 1'b0;
        load_take = 1'b0;
        case (state)
            S_IDLE: begin
                if (ev_clr)     clr_take = 1'b1;
                else if (ev_ss) state_nx = S_RUN;
            end
            S_RUN: begin
                if (ev_ss) state_nx = S_PAUSE;
`ifdef STOPWATCH_LAP_EN
                else if (ev_lap) begin
                    state_nx  = S_LAP_RUN;
                    load_take = 1'b1;
                end
`endif
            end
            S_PAUSE: begin
                if (ev_clr) begin
                    state_nx = S_IDLE;
                    clr_take = 1'b1;
                end else if (ev_ss) begin
                    state_nx = S_RUN;
                end
            end
`ifdef STOPWATCH_LAP_EN
            S_LAP_RUN: begin
                if (ev_clr)      state_nx  = S_RUN;
                else if (ev_ss)  state_nx  = S_LAP_PAUSE;
                else if (ev_lap) load_take = 1'b1;
            end
            S_LAP_PAUSE: begin
                if (ev_ss)                 state_nx = S_LAP_RUN;
                else if (ev_clr || ev_lap) state_nx = S_PAUSE;
            end
`endif
            default: state_nx = S_IDLE;
        endcase
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                             lap_count <= 4'd0;
        else if (clr_take)                      lap_count <= 4'd0;
        else if (load_take && lap_count != 4'd15) lap_count <= lap_count + 4'd1;
    end

    always_comb begin
        running      = (state == S_RUN) || (state == S_LAP_RUN);
        display_hold = (state == S_LAP_RUN) || (state == S_LAP_PAUSE);
        count_en     = tick & running;
    end
`else
    assign lap_count = 4'd0;

    always_comb begin
        running      = (state == S_RUN);
        display_hold = 1'b0;
        count_en     = tick & running;
    end
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with short dividers (TICK_DIV=4, DEB_DIV=2).
// Lap expectations collapse to zero when STOPWATCH_LAP_EN is not defined.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ss_pulse = 1'b0, lap_pulse = 1'b0, clr_pulse = 1'b0;
    logic       deb_en, tick, count_en, count_clr, display_hold, hold_load, running;
    logic [3:0] lap_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tick_base = 0;

    stopwatch_ctrl #(.TICK_DIV(4), .DEB_DIV(2), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .ss_pulse(ss_pulse), .lap_pulse(lap_pulse), .clr_pulse(clr_pulse),
        .deb_en(deb_en), .tick(tick), .count_en(count_en), .count_clr(count_clr),
        .display_hold(display_hold), .hold_load(hold_load), .running(running),
        .lap_count(lap_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0h exp %0h", tag, cyc, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic s, input logic l, input logic c);
        ss_pulse  = s;
        lap_pulse = l;
        clr_pulse = c;
        step();
        ss_pulse  = 1'b0;
        lap_pulse = 1'b0;
        clr_pulse = 1'b0;
    endtask

    // Tick phase follows tick_base (last prescaler restart); lap outputs are tied off without the lap build.
    task automatic exp_state(input logic run, input logic dh, input logic hl,
                             input logic [3:0] lc, input logic cc);
        logic t;
        t = (cyc > tick_base) && (((cyc - tick_base) % 4) == 0);
        chk("tick", tick, t);
        chk("deb_en", deb_en, (cyc % 2) == 0);
        chk("count_en", count_en, t & run);
        chk("running", running, run);
        chk("count_clr", count_clr, cc);
`ifdef STOPWATCH_LAP_EN
        chk("display_hold", display_hold, dh);
        chk("hold_load", hold_load, hl);
        chk("lap_count", lap_count, lc);
`else
        chk("display_hold", display_hold, 1'b0);
        chk("hold_load", hold_load, 1'b0);
        chk("lap_count", lap_count, 4'd0);
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tick"}, tick, 0);
        chk({tag, "_deb_en"}, deb_en, 0);
        chk({tag, "_count_en"}, count_en, 0);
        chk({tag, "_count_clr"}, count_clr, 0);
        chk({tag, "_running"}, running, 0);
        chk({tag, "_display_hold"}, display_hold, 0);
        chk({tag, "_hold_load"}, hold_load, 0);
        chk({tag, "_lap_count"}, lap_count, 0);
    endtask

    initial begin
        #12;
        chk_all_zero("rst");
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;

        // Free-running strobes, ss at 10 starts, ss at 16 (tick cycle) stops.
        for (int i = 0; i < 21; i++) begin
            ss_pulse = (cyc == 10) || (cyc == 16);
            step();
            exp_state((cyc >= 11) && (cyc <= 16), 0, 0, 0, 0);
        end
        ss_pulse = 1'b0;

        // PAUSE -> RUN, two laps, ss, lap.
        drive(1, 0, 0); exp_state(1, 0, 0, 0, 0);
        drive(0, 1, 0); exp_state(1, 1, 1, 1, 0);
        drive(0, 1, 0); exp_state(1, 1, 1, 2, 0);
        drive(1, 0, 0); exp_state(0, 1, 0, 2, 0);
        drive(0, 1, 0); exp_state(0, 0, 0, 2, 0);

        // clr+ss+lap in PAUSE: only clr wins, tick phase restarts.
        drive(1, 1, 1);
        tick_base = cyc;
        exp_state(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            exp_state(0, 0, 0, 0, 0);
        end

        // Sixteen consecutive laps from RUN: counter saturates, loads keep coming.
        drive(1, 0, 0); exp_state(1, 0, 0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            drive(0, 1, 0);
            exp_state(1, 1, 1, (k > 15) ? 4'd15 : 4'(k), 0);
        end
        step(); exp_state(1, 1, 0, 15, 0);
        step(); exp_state(1, 1, 0, 15, 0);
        step(); exp_state(1, 1, 0, 15, 0);

        // Asynchronous reset mid-lap while tick/count_en are high.
        reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        tick_base = 0;

        // Back in IDLE: ss starts, ss,ss back-to-back, clr in RUN ignored.
        for (int i = 0; i < 12; i++) begin
            ss_pulse  = (cyc == 5) || (cyc == 6) || (cyc == 7);
            clr_pulse = (cyc == 8);
            step();
            exp_state((cyc >= 6) && (cyc != 7), 0, 0, 0, 0);
        end
        ss_pulse  = 1'b0;
        clr_pulse = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
